// File: rtl/cpa_pkg.sv
// Shared configuration helpers for the pipelined carry-propagate adder.
package cpa_pkg;

    // Number of ripple slices (and pipeline stages) for a given geometry.
    function automatic int unsigned cpa_stages(input int unsigned width,
                                               input int unsigned slice);
        return (slice == 0) ? 0 : width / slice;
    endfunction

    // Legal geometry: at least one whole slice and no partial slice.
    function automatic bit cpa_cfg_ok(input int unsigned width,
                                      input int unsigned slice);
        return (slice != 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cpa_if.sv
// Operand/result handshake bundle for pipelined_cpa.
interface pipelined_cpa_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf
    );
endinterface

// File: rtl/cpa_slice.sv
// Combinational SLICE-bit ripple of full adders; also exposes the carry
// into the slice MSB so the top slice can derive signed overflow.
module cpa_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] s,
    output logic             c_out,
    output logic             c_msb
);
    logic [SLICE:0] c;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = c_in;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Carry out of the slice and carry into its top bit.
    always_comb begin
        c_out = c[SLICE];
        c_msb = c[SLICE-1];
    end
endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor: one acceptance register that
// conditions the operands, then one ripple slice per stage with skewed
// operands in and deskewed result slices out. A single global stall freezes
// every register while the result bus is backpressured.
module pipelined_cpa
    import cpa_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic            clk,
    input logic            rst,
    pipelined_cpa_if.slave bus
);
    localparam int unsigned STAGES = cpa_stages(WIDTH, SLICE);

    if (!cpa_cfg_ok(WIDTH, SLICE)) begin : g_cfg_check
        $error("pipelined_cpa: WIDTH must be a nonzero multiple of SLICE");
    end

    logic stall;
    logic out_valid;

    logic             acc_valid_d, acc_valid_q;
    logic             acc_cin_d, acc_cin_q;
    logic [WIDTH-1:0] acc_a_d, acc_a_q;
    logic [WIDTH-1:0] acc_b_d, acc_b_q;

    // Global stall and the ready/valid seen by both ends of the pipe.
    always_comb begin
        out_valid     = g_stg[STAGES-1].valid_q;
        stall         = out_valid & ~bus.out_ready;
        bus.in_ready  = ~stall;
        bus.out_valid = out_valid;
        bus.s         = g_stg[STAGES-1].res_q;
        bus.c_out     = g_stg[STAGES-1].carry_q;
        bus.ovf       = g_stg[STAGES-1].g_tail.ovf_q;
    end

    // Fold subtract into the operands once so every slice is a plain add.
    always_comb begin
        acc_valid_d = bus.in_valid;
        acc_a_d     = bus.a;
        acc_b_d     = bus.sub ? ~bus.b : bus.b;
        acc_cin_d   = bus.c_in ^ bus.sub;
    end

    // Acceptance register; a beat is taken whenever the pipe is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid_q <= 1'b0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            acc_cin_q   <= 1'b0;
        end else if (!stall) begin
            acc_valid_q <= acc_valid_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            acc_cin_q   <= acc_cin_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned DONE = (k + 1) * SLICE;
        localparam int unsigned REM  = WIDTH - DONE;

        // Operand bits not yet consumed when this stage starts.
        logic [WIDTH-k*SLICE-1:0] op_a, op_b;
        logic [SLICE-1:0]         sl_a, sl_b, sl_s;
        logic                     sl_cin, sl_cout, sl_cmsb;
        logic                     prev_valid;

        logic            valid_d, valid_q;
        logic            carry_d, carry_q;
        logic [DONE-1:0] res_d, res_q;

        if (k == 0) begin : g_head
            // First slice reads the acceptance register directly.
            always_comb begin
                op_a       = acc_a_q;
                op_b       = acc_b_q;
                sl_cin     = acc_cin_q;
                prev_valid = acc_valid_q;
                res_d      = sl_s;
            end
        end else begin : g_body
            // Later slices take the skewed operands and the registered carry.
            always_comb begin
                op_a       = g_stg[k-1].g_skew.a_q;
                op_b       = g_stg[k-1].g_skew.b_q;
                sl_cin     = g_stg[k-1].carry_q;
                prev_valid = g_stg[k-1].valid_q;
                res_d      = {sl_s, g_stg[k-1].res_q};
            end
        end

        // Lowest remaining slice feeds this stage's ripple.
        always_comb begin
            sl_a    = op_a[SLICE-1:0];
            sl_b    = op_b[SLICE-1:0];
            valid_d = prev_valid;
            carry_d = sl_cout;
        end

        cpa_slice #(.SLICE(SLICE)) u_slice (
            .a     (sl_a),
            .b     (sl_b),
            .c_in  (sl_cin),
            .s     (sl_s),
            .c_out (sl_cout),
            .c_msb (sl_cmsb)
        );

        // Stage register: valid bit, carry and the finished lower result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (!stall) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        if (REM > 0) begin : g_skew
            logic [REM-1:0] a_d, a_q, b_d, b_q;

            // Carry the still-unused upper slices forward.
            always_comb begin
                a_d = op_a[WIDTH-k*SLICE-1:SLICE];
                b_d = op_b[WIDTH-k*SLICE-1:SLICE];
            end

            // Skew register for the upper operand slices.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic ovf_d, ovf_q;

            // Signed overflow: carry into MSB differs from carry out of it.
            always_comb begin
                ovf_d = sl_cmsb ^ sl_cout;
            end

            // Overflow flag registered alongside the final result slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cpa.sv
// Scoreboard bench for pipelined_cpa at WIDTH=16, SLICE=4.
module tb_pipelined_cpa;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 4;
    localparam int          STAGES = 4;

    logic clk = 1'b0;
    logic rst;

    pipelined_cpa_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cpa #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outs_seen = 0;
    logic [17:0] exp_q[$];
    logic last_cout = 1'b0;
    bit lat_armed = 1'b0;
    int lat_accept = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: integer arithmetic on the unconditioned operands.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sb);
        int full;
        int sres;
        logic [15:0] sv;
        logic co;
        logic ov;
        if (!sb) begin
            full = int'(a) + int'(b) + int'(cin);
            sres = int'($signed(a)) + int'($signed(b)) + int'(cin);
            co   = (full > 65535);
        end else begin
            full = int'(a) - int'(b) - int'(cin);
            sres = int'($signed(a)) - int'($signed(b)) - int'(cin);
            co   = (full >= 0);
        end
        sv = full[15:0];
        ov = (sres > 32767) || (sres < -32768);
        return {sv, co, ov};
    endfunction

    // Result monitor: pops the scoreboard on every transfer.
    always @(negedge clk) begin
        logic [17:0] e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("s", 32'(bus.s), 32'(e[17:2]));
                check_eq("c_out", 32'(bus.c_out), 32'(e[1]));
                check_eq("ovf", 32'(bus.ovf), 32'(e[0]));
            end
            last_cout = bus.c_out;
            outs_seen++;
            if (lat_armed) begin
                check_eq("latency", 32'(cyc - lat_accept), 32'(STAGES));
                lat_armed = 1'b0;
            end
        end
    end

    // Present one beat until accepted; call at posedge+1, returns at posedge+1.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sb, input logic [17:0] e, input bit arm);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.sub      = sb;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (bus.in_ready === 1'b1);
        end
        if (!ok) begin
            check_eq("send_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(e);
            if (arm) begin
                lat_armed  = 1'b1;
                lat_accept = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb);
        send(a, b, cin, sb, model(a, b, cin, sb), 1'b0);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int target, input int budget);
        int n = 0;
        while (outs_seen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (outs_seen < target) check_eq("wait_out", 32'(outs_seen), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_s", 32'(bus.s), 32'd0);
        check_eq("rst_c_out", 32'(bus.c_out), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #1;

        // Plain add with latency measurement on an empty pipe.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0}, 1'b1);
        idle();
        wait_outs(1, 20);

        // Carry ripple, signed overflow, subtract with borrow in/out.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0}, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFD, 1'b0, 1'b0}, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1}, 1'b0);
        send_m(16'h0007, 16'h0005, 1'b0, 1'b1);
        idle();
        wait_outs(7, 30);

        // Streaming with a 3-cycle backpressure window.
        base = outs_seen;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_m(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
                idle();
            end
            begin
                bit seen = 1'b0;
                for (int n = 0; n < 40 && !seen; n++) begin
                    @(negedge clk);
                    seen = (bus.out_valid === 1'b1);
                end
                if (!seen) check_eq("stream_start", 32'd0, 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("in_ready_stall", 32'(bus.in_ready), 32'd0);
                    check_eq("out_valid_hold", 32'(bus.out_valid), 32'd1);
                    if (exp_q.size() != 0) check_eq("s_hold", 32'(bus.s), 32'(exp_q[0][17:2]));
                    else check_eq("s_hold_queue", 32'd0, 32'd1);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_outs(base + 8, 60);
        check_eq("stream_count", 32'(outs_seen - base), 32'd8);
        check_eq("stream_drained", 32'(exp_q.size()), 32'd0);

        // 32-bit chaining: low word carry feeds the high word.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}, 1'b0);
        idle();
        wait_outs(outs_seen + 1, 20);
        send(16'h0001, 16'h0000, last_cout, 1'b0, {16'h0002, 1'b0, 1'b0}, 1'b0);
        idle();
        wait_outs(outs_seen + 1, 20);

        // Leave nonzero fields in the output registers, then reset mid-flight.
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1}, 1'b0);
        idle();
        wait_outs(outs_seen + 1, 20);
        base = outs_seen;
        send_m(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_m(16'h3333, 16'h0444, 1'b1, 1'b1);
        send_m(16'hABCD, 16'h1234, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_s", 32'(bus.s), 32'd0);
        check_eq("flush_c_out", 32'(bus.c_out), 32'd0);
        check_eq("flush_ovf", 32'(bus.ovf), 32'd0);
        check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check_eq("flush_no_output", 32'(outs_seen - base), 32'd0);

        // Pipe recovers after the flush.
        send(16'h00FF, 16'h0F01, 1'b1, 1'b0, {16'h1001, 1'b0, 1'b0}, 1'b1);
        idle();
        wait_outs(outs_seen + 1, 20);
        check_eq("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
